// File: rtl/rs_ff_checker.sv
// Observer for a clocked RS flip-flop: keeps a one-cycle-ahead reference model,
// flags output mismatches and forbidden R=S=1 inputs, and counts both with saturation.
module rs_ff_checker #(
    parameter int MAX_ERR = 4,
    parameter int CNT_W   = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             En,
    input  logic             R,
    input  logic             S,
    input  logic             Q,
    input  logic             Qn,
    output logic             Exp_Q,
    output logic             Exp_Vld,
    output logic             Err,
    output logic             Forbid,
    output logic [CNT_W-1:0] Err_Cnt,
    output logic [CNT_W-1:0] Forb_Cnt,
    output logic             Fail,
    output logic [1:0]       St
);

    localparam logic [1:0]       ST_UNKNOWN = 2'b00;
    localparam logic [1:0]       ST_TRACK   = 2'b01;
    localparam logic [1:0]       ST_FAULT   = 2'b10;
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ERR_LIMIT  = CNT_W'(MAX_ERR);

    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic [1:0]       st_s;
    logic             exp_q_r;
    logic             exp_vld_r;
    logic             err_r;
    logic             forbid_r;
    logic             fail_r;
    logic [CNT_W-1:0] err_cnt_r;
    logic [CNT_W-1:0] forb_cnt_r;
    logic             drive_s;
    logic             forbid_s;
    logic             mismatch_s;
    logic             fault_hit_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Decode sampled inputs; the check compares against the prediction held from the previous edge.
    always_comb begin
        drive_s  = S ^ R;
        forbid_s = S & R;
        if (exp_vld_r) begin
            mismatch_s = (Q != exp_q_r) | (Qn == Q);
        end else begin
            mismatch_s = 1'b0;
        end
        fault_hit_s = mismatch_s && (err_cnt_r != ERR_LIMIT) && (sat_inc(err_cnt_r) == ERR_LIMIT);
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r <= ST_UNKNOWN;
        end else if (En) begin
            state_r <= state_s;
        end else begin
            state_r <= state_r;
        end
    end

    // FSM next-state logic; reaching the error limit overrides any tracking transition.
    always_comb begin
        state_s = state_r;
        if (fault_hit_s) begin
            state_s = ST_FAULT;
        end else begin
            case (state_r)
                ST_UNKNOWN: state_s = drive_s  ? ST_TRACK   : ST_UNKNOWN;
                ST_TRACK:   state_s = forbid_s ? ST_UNKNOWN : ST_TRACK;
                ST_FAULT:   state_s = ST_FAULT;
                default:    state_s = ST_UNKNOWN;
            endcase
        end
    end

    // FSM output decode.
    always_comb begin
        st_s = ST_UNKNOWN;
        case (state_r)
            ST_UNKNOWN: st_s = ST_UNKNOWN;
            ST_TRACK:   st_s = ST_TRACK;
            ST_FAULT:   st_s = ST_FAULT;
            default:    st_s = ST_UNKNOWN;
        endcase
    end

    // Reference model, event pulses, counters and sticky fail.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            exp_q_r    <= 1'b0;
            exp_vld_r  <= 1'b0;
            err_r      <= 1'b0;
            forbid_r   <= 1'b0;
            fail_r     <= 1'b0;
            err_cnt_r  <= {CNT_W{1'b0}};
            forb_cnt_r <= {CNT_W{1'b0}};
        end else if (En) begin
            if (forbid_s) begin
                exp_vld_r <= 1'b0;
            end else if (drive_s) begin
                exp_q_r   <= S;
                exp_vld_r <= 1'b1;
            end else begin
                exp_vld_r <= exp_vld_r;
            end
            err_r    <= mismatch_s;
            forbid_r <= forbid_s;
            if (mismatch_s) begin
                err_cnt_r <= sat_inc(err_cnt_r);
            end else begin
                err_cnt_r <= err_cnt_r;
            end
            if (forbid_s) begin
                forb_cnt_r <= sat_inc(forb_cnt_r);
            end else begin
                forb_cnt_r <= forb_cnt_r;
            end
            fail_r <= fail_r | fault_hit_s;
        end else begin
            err_r    <= 1'b0;
            forbid_r <= 1'b0;
        end
    end

    assign Exp_Q    = exp_q_r;
    assign Exp_Vld  = exp_vld_r;
    assign Err      = err_r;
    assign Forbid   = forbid_r;
    assign Err_Cnt  = err_cnt_r;
    assign Forb_Cnt = forb_cnt_r;
    assign Fail     = fail_r;
    assign St       = st_s;

endmodule
